// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter and write sequencer for a shared level-sensitive latch bank.
// Each write runs SETUP -> ENABLE (EN_CYCLES) -> HOLD, so D is stable around the gate.
module latch_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                   clr,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       lat_d,
  output logic                   lat_en,
  output logic                   lat_rst,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW1   = PTR_W + 1;
  localparam int CNT_W = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SETUP, ENABLE, HOLD} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [PTR_W-1:0]   win, win_nxt, win_pick;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   gnt_nxt, done_nxt;
  logic [WIDTH-1:0]   lat_d_nxt;
  logic               lat_en_nxt, lat_rst_nxt;

  // First requester at or after p, wrapping modulo N_REQ.
  function automatic logic [PTR_W-1:0] pick(input logic [N_REQ-1:0] r,
                                            input logic [PTR_W-1:0] p);
    logic [PW1-1:0]   s;
    logic [PTR_W-1:0] w;
    logic             found;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      s = {1'b0, p} + PW1'(i);
      if (s >= PW1'(N_REQ)) s = s - PW1'(N_REQ);
      if (!found && r[s[PTR_W-1:0]]) begin
        found = 1'b1;
        w     = s[PTR_W-1:0];
      end
    end
    return w;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
    logic [PW1-1:0] s;
    s = {1'b0, w} + PW1'(1);
    if (s >= PW1'(N_REQ)) s = '0;
    return s[PTR_W-1:0];
  endfunction

  assign win_pick = pick(req, ptr);

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    win_nxt     = win;
    cnt_nxt     = cnt;
    gnt_nxt     = gnt;
    done_nxt    = '0;
    lat_d_nxt   = lat_d;
    lat_en_nxt  = 1'b0;
    lat_rst_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt   = CLEAR;
          gnt_nxt     = '0;
          lat_rst_nxt = 1'b1;
        end else if (|req) begin
          state_nxt = SETUP;
          win_nxt   = win_pick;
          for (int i = 0; i < N_REQ; i++) begin
            gnt_nxt[i] = (win_pick == PTR_W'(i));
            if (win_pick == PTR_W'(i)) lat_d_nxt = wdata[i*WIDTH +: WIDTH];
          end
        end
      end
      CLEAR: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
      SETUP: begin
        state_nxt  = ENABLE;
        lat_en_nxt = 1'b1;
        cnt_nxt    = '0;
      end
      ENABLE: begin
        // Gate closes one cycle before done so D stays put through HOLD.
        if (cnt == CNT_W'(EN_CYCLES - 1)) begin
          state_nxt = HOLD;
          done_nxt  = gnt;
        end else begin
          cnt_nxt    = cnt + CNT_W'(1);
          lat_en_nxt = 1'b1;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        ptr_nxt   = next_ptr(win);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      done    <= '0;
      lat_d   <= '0;
      lat_en  <= 1'b0;
      lat_rst <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      win     <= win_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      lat_d   <= lat_d_nxt;
      lat_en  <= lat_en_nxt;
      lat_rst <= lat_rst_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed, table-driven bench for latch_write_arbiter (N_REQ=4, WIDTH=8, EN_CYCLES=2).
module tb_latch_write_arbiter;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt, done;
  logic [7:0]  lat_d;
  logic        lat_en, lat_rst, busy;
  logic [7:0]  latch_q;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        clr;
    logic [31:0] wd;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  d;
    logic        en;
    logic        lr;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] W0 = 32'h4433_2211;
  localparam logic [31:0] W2 = 32'h4433_A511;

  latch_write_arbiter #(.N_REQ(4), .WIDTH(8), .EN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .clr(clr),
    .gnt(gnt), .done(done), .lat_d(lat_d), .lat_en(lat_en),
    .lat_rst(lat_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the attached D-latch bank.
  always_latch begin
    if (lat_rst)     latch_q <= 8'h00;
    else if (lat_en) latch_q <= lat_d;
  end

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic c,
                              input logic [31:0] wd, input logic [3:0] g,
                              input logic [3:0] dn, input logic [7:0] d,
                              input logic en, input logic lr, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.clr = c; v.wd = wd;
    v.gnt = g; v.done = dn; v.d = d; v.en = en; v.lr = lr; v.busy = b;
    return v;
  endfunction

  // One complete write from IDLE: grant, SETUP, two ENABLE cycles, HOLD, back to IDLE.
  task automatic txn(input logic [3:0] r, input logic [31:0] wd, input int w,
                     input logic [7:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    vecs.push_back(mk(1'b0, r, 1'b0, wd, oh,   4'h0, d, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, r, 1'b0, wd, oh,   4'h0, d, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, r, 1'b0, wd, oh,   4'h0, d, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, r, 1'b0, wd, oh,   oh,   d, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, r, 1'b0, wd, 4'h0, 4'h0, d, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic apply(input string nm, input vec_t v);
    rst = v.rst; req = v.req; clr = v.clr; wdata = v.wd;
    @(posedge clk);
    #1;
    n_cmp++;
    if (gnt !== v.gnt || done !== v.done || lat_d !== v.d || lat_en !== v.en ||
        lat_rst !== v.lr || busy !== v.busy) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b done=%b lat_d=%h lat_en=%b lat_rst=%b busy=%b; want gnt=%b done=%b lat_d=%h lat_en=%b lat_rst=%b busy=%b",
               nm, gnt, done, lat_d, lat_en, lat_rst, busy,
               v.gnt, v.done, v.d, v.en, v.lr, v.busy);
    end
  endtask

  task automatic run_table(input string grp);
    for (int i = 0; i < vecs.size(); i++) apply($sformatf("%s[%0d]", grp, i), vecs[i]);
    vecs.delete();
  endtask

  task automatic chk_q(input string nm, input logic [7:0] exp);
    n_cmp++;
    if (latch_q !== exp) begin
      n_bad++;
      $display("FAIL %s: got latch_q=%h want %h", nm, latch_q, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b1; req = 4'hF; wdata = W0;

    // Reset held with everything asserted, then round-robin under full load.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b1, 4'hF, 1'b1, W0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0));
    txn(4'hF, W0, 0, 8'h11);
    txn(4'hF, W0, 1, 8'h22);
    txn(4'hF, W0, 2, 8'h33);
    txn(4'hF, W0, 3, 8'h44);
    txn(4'hF, W0, 0, 8'h11);
    // Single write from requester 1, then idle.
    txn(4'b0010, W2, 1, 8'hA5);
    vecs.push_back(mk(1'b0, 4'h0, 1'b0, W2, 4'h0, 4'h0, 8'hA5, 1'b0, 1'b0, 1'b0));
    run_table("rr");
    chk_q("latch_a5", 8'hA5);

    // Wrap: serve 2 (ptr -> 3), then {1,0} requesting grants 0 before 1.
    txn(4'b0100, W0, 2, 8'h33);
    txn(4'b0011, W0, 0, 8'h11);
    txn(4'b0011, W0, 1, 8'h22);
    run_table("wrap");

    // clr beats a pending req in IDLE.
    apply("clr_win", mk(1'b0, 4'b0100, 1'b1, W0, 4'h0, 4'h0, 8'h22, 1'b0, 1'b1, 1'b1));
    chk_q("latch_clr", 8'h00);
    apply("clr_exit", mk(1'b0, 4'b0100, 1'b0, W0, 4'h0, 4'h0, 8'h22, 1'b0, 1'b0, 1'b0));
    // clr pulsed during ENABLE and dropped before IDLE is ignored.
    apply("c_gnt",  mk(1'b0, 4'b0100, 1'b0, W0, 4'b0100, 4'h0,    8'h33, 1'b0, 1'b0, 1'b1));
    apply("c_en0",  mk(1'b0, 4'b0100, 1'b0, W0, 4'b0100, 4'h0,    8'h33, 1'b1, 1'b0, 1'b1));
    apply("c_en1",  mk(1'b0, 4'b0100, 1'b1, W0, 4'b0100, 4'h0,    8'h33, 1'b1, 1'b0, 1'b1));
    apply("c_hold", mk(1'b0, 4'b0100, 1'b0, W0, 4'b0100, 4'b0100, 8'h33, 1'b0, 1'b0, 1'b1));
    apply("c_idle", mk(1'b0, 4'h0,    1'b0, W0, 4'h0,    4'h0,    8'h33, 1'b0, 1'b0, 1'b0));
    apply("c_noclr",mk(1'b0, 4'h0,    1'b0, W0, 4'h0,    4'h0,    8'h33, 1'b0, 1'b0, 1'b0));
    chk_q("latch_33", 8'h33);

    // Reset during ENABLE of a requester-1 write aborts it; ptr returns to 0.
    vecs.push_back(mk(1'b0, 4'b0010, 1'b0, W0, 4'b0010, 4'h0, 8'h22, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 4'b0010, 1'b0, W0, 4'b0010, 4'h0, 8'h22, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 4'b0010, 1'b0, W0, 4'h0,    4'h0, 8'h00, 1'b0, 1'b1, 1'b0));
    txn(4'hF, W0, 0, 8'h11);
    run_table("abort");
    chk_q("latch_11", 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/latch_write_arbiter.md
Name: latch_write_arbiter

Overview:
Round-robin arbiter and write sequencer that shares one WIDTH-bit level-sensitive D-latch bank between N_REQ requesters. It drives the bank's data (lat_d), gate (lat_en) and reset (lat_rst) with a fixed setup / enable / hold sequence, so D is stable before the gate opens and after it closes. It also provides a clear path that takes priority over writes. It sits between the requesting FSMs and the DLatch array.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, latch bank data width
EN_CYCLES, 2, cycles lat_en is held high per write; minimum 1, 0 is illegal

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester write request, level; held until matching done
wdata  input  N_REQ*WIDTH  requester i data = wdata[i*WIDTH +: WIDTH]
clr  input  1  request to clear the latch bank, level, sampled in IDLE only
gnt  output  N_REQ  one-hot grant, registered
done  output  N_REQ  one-cycle completion pulse per requester
lat_d  output  WIDTH  data to latch bank D inputs
lat_en  output  1  latch gate
lat_rst  output  1  latch bank reset
busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset values (at the edge where rst=1): state=IDLE, ptr=0, gnt=0, done=0, lat_d=0, lat_en=0, lat_rst=1, busy=0.
- rst has priority over everything. If rst is asserted mid-transaction, the in-flight write is aborted at the next edge. There is no done for it, and lat_en is 0 after that edge.
- States: IDLE, CLEAR, SETUP, ENABLE, HOLD.
- IDLE, priority order:
  - rst: stay in reset (reset values above).
  - clr=1: go to CLEAR.
  - Else, if req != 0: winner = first set bit scanning ptr, ptr+1, ..., wrapping modulo N_REQ. Register gnt = one-hot(winner) and lat_d = winner's wdata slice, then go to SETUP.
  - Else: stay in IDLE.
  - In IDLE, lat_rst=0 and lat_en=0.
- CLEAR: lat_rst=1 for exactly one cycle, gnt=0, then IDLE. ptr is unchanged.
- SETUP: one cycle. lat_en=0, gnt and lat_d held. Then ENABLE.
- ENABLE: exactly EN_CYCLES cycles with lat_en=1, counted by an internal counter. gnt and lat_d held. Then HOLD.
- HOLD: one cycle. lat_en=0, lat_d held, done[winner]=1 for this cycle only. At exit: gnt=0, ptr=(winner+1) mod N_REQ, next state IDLE.
- Timing: a req sampled in IDLE at edge k gives:
  - gnt at k+1
  - lat_en high from k+2 to k+1+EN_CYCLES
  - done at k+2+EN_CYCLES
  - IDLE at k+3+EN_CYCLES
  - Total: one grant every EN_CYCLES+3 cycles under continuous load.
- wdata and req are ignored outside IDLE.
- If a requester drops req mid-transaction, the write still completes and done still pulses.
- A requester still asserting req after its done is re-arbitrated fairly (ptr has advanced past it).
- clr asserted outside IDLE is not latched. It takes effect only if still high when IDLE is reached, and then beats any pending req in that cycle.
- Invariants: gnt is 0 or one-hot; lat_en is never 1 in the same cycle as lat_rst; lat_d never changes while lat_en=1 or in the cycle after it falls.

Test Plan:
(All with N_REQ=4, WIDTH=8, EN_CYCLES=2.)
1. Reset: rst=1 for 3 cycles with req=4'b1111 and clr=1. Required: gnt=0, done=0, lat_en=0, lat_rst=1, lat_d=8'h00, busy=0 throughout. After release with req=1111, the first grant is 4'b0001.
2. Single write: req=4'b0010, wdata slice1=8'hA5, sampled at edge k. Required: gnt=0010 and lat_d=A5 at k+1; lat_en=1 at k+2 and k+3 only; done=0010 at k+4; idle at k+5. The attached DLatch Q reads 8'hA5 afterwards.
3. Round-robin: req=4'b1111 held, slices 8'h11/22/33/44. Required: grant order 0,1,2,3,0, one grant every 5 cycles; lat_d sequence 11,22,33,44,11.
4. Wrap: serve requester 2 (ptr becomes 3), then req=4'b0011. Required: requester 0 is granted first, then 1.
5. clr and req=4'b0100 both high in IDLE. Required: lat_rst=1 for one cycle with gnt=0, then gnt=0100 on the following transaction. clr pulsed during ENABLE and dropped before IDLE: no CLEAR occurs.
6. rst=1 for one cycle during ENABLE of a requester-1 write. Required: lat_en=0, gnt=0, lat_rst=1 at the next edge; done[1] never pulses. Afterwards req=1111 grants requester 0.
